sync_edge_mc: RTL and testbench
===============================

SYNC_EDGE_MC -- requirements
Module: sync_edge_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent asynchronous input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flip-flop depth per channel (2..4).
REQ-003 Parameter FILTER_LEN, default 3: consecutive stable cycles required before a filtered level change (0 = filter bypassed, max 255).
REQ-004 i_reset_n  input  1  asynchronous active-low reset; clears all state when low.
REQ-005 i_clk  input  1  single clock; all outputs registered on its rising edge.
REQ-006 i_async_in  input  CHANNELS  asynchronous level inputs, no timing relation to i_clk.
REQ-007 i_mode  input  2*CHANNELS  per-channel edge select, bits [2n+1:2n]: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 i_clear  input  CHANNELS  per-channel synchronous clear of o_pending and o_overrun.
REQ-009 o_level  output  CHANNELS  synchronized, filtered level per channel.
REQ-010 o_pulse  output  CHANNELS  one-cycle event strobe per channel.
REQ-011 o_pending  output  CHANNELS  sticky event flag per channel.
REQ-012 o_overrun  output  CHANNELS  sticky flag: event occurred while pending already set.

Function
REQ-013 Each channel shall pass i_async_in[n] through a SYNC_STAGES-deep flip-flop chain clocked by i_clk; no logic between chain stages.
REQ-014 Filter: per-channel counter, width sufficient for FILTER_LEN; counter resets to 0 whenever synchronized value equals o_level[n], otherwise increments.
REQ-015 o_level[n] shall take the synchronized value on the edge where the counter would reach FILTER_LEN, counter returns to 0 in the same cycle.
REQ-016 FILTER_LEN = 0: o_level[n] shall follow the last synchronizer stage with one register of delay; counter logic absent.
REQ-017 Latency: input change stable from clock edge k yields o_level change at edge k+SYNC_STAGES+FILTER_LEN (k+SYNC_STAGES+1 when FILTER_LEN=0... counted as k+SYNC_STAGES+max(FILTER_LEN,1)).
REQ-018 Glitch shorter than FILTER_LEN cycles after synchronization shall produce no o_level change and no event.
REQ-019 Event: o_level[n] transition matching i_mode[n] (0->1 for 01, 1->0 for 10, either for 11); mode 00 never produces an event.
REQ-020 o_pulse[n] shall be high for exactly the one cycle in which o_level[n] holds its new value after a qualifying transition, low otherwise.
REQ-021 o_pending[n] shall set on the same edge that o_pulse[n] asserts and hold until i_clear[n].
REQ-022 o_overrun[n] shall set when an event occurs while o_pending[n] is already 1 and i_clear[n] is 0; holds until i_clear[n].
REQ-023 Simultaneous i_clear[n] and event: o_pending[n] ends 1, o_overrun[n] ends 0 (event wins, clear consumes previous event).
REQ-024 i_clear[n] with no event: o_pending[n] and o_overrun[n] cleared next edge; o_level unaffected.
REQ-025 i_mode is sampled each cycle; a change applies to transitions occurring on the next edge onward; pending/overrun unaffected by mode change.
REQ-026 Channels shall be fully independent; no cross-channel interaction in any signal.

Reset
REQ-027 While i_reset_n low: synchronizer chains, filter counters, o_level, o_pulse, o_pending, o_overrun all 0.
REQ-028 Reset assertion mid-filter or mid-event shall discard all in-progress state; no pulse generated during or by reset.
REQ-029 Input held high across reset release shall be treated as a 0->1 transition, producing a rising event after REQ-017 latency.

Verification
REQ-030 SYNC_STAGES=2, FILTER_LEN=3, mode 01, ch0 rises and stays high -> o_level[0] and o_pulse[0] at edge k+5, pulse width 1 cycle, o_pending[0]=1.
REQ-031 FILTER_LEN=3, ch1 high for 2 synchronized cycles then low -> no o_level, o_pulse, o_pending change.
REQ-032 Mode 11, ch2 rising then falling (each stable 10 cycles), no clear -> two pulses, o_pending[2]=1, o_overrun[2]=1; i_clear[2] -> both 0 next edge.
REQ-033 Event on ch3 in same cycle as i_clear[3] with pending set -> o_pending[3]=1, o_overrun[3]=0.
REQ-034 Mode 00 on ch0 with toggling input -> o_level tracks, o_pulse/o_pending stay 0; mode 10 then falling edge -> single pulse.
REQ-035 Reset asserted while ch1 filter count = 2 -> all outputs 0 immediately; input high at release -> rising event after full latency.

Source files
------------

// File: rtl/sync_edge_mc_if.sv
// Signal bundle for sync_edge_mc: async level inputs, per-channel control and event outputs.
interface sync_edge_mc_if #(
   parameter int unsigned CHANNELS = 4
);
   logic [CHANNELS-1:0]   i_async_in;
   logic [2*CHANNELS-1:0] i_mode;
   logic [CHANNELS-1:0]   i_clear;
   logic [CHANNELS-1:0]   o_level;
   logic [CHANNELS-1:0]   o_pulse;
   logic [CHANNELS-1:0]   o_pending;
   logic [CHANNELS-1:0]   o_overrun;

   // Driver side (system / testbench)
   modport master (
      output i_async_in, i_mode, i_clear,
      input  o_level, o_pulse, o_pending, o_overrun
   );

   // Block side
   modport slave (
      input  i_async_in, i_mode, i_clear,
      output o_level, o_pulse, o_pending, o_overrun
   );
endinterface

// File: rtl/sync_edge_mc.sv
// Multi-channel async input synchronizer with glitch filter and per-channel edge event capture.
module sync_edge_mc #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 3
) (
   input logic           i_clk,
   input logic           i_reset_n,
   sync_edge_mc_if.slave bus
);

   // Reject unsupported parameter sets at elaboration
   if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN > 255) begin : g_bad_param
      $error("sync_edge_mc: parameter out of range");
   end

   logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_last;

   logic [CHANNELS-1:0] level_d,   level_q;
   logic [CHANNELS-1:0] pulse_d,   pulse_q;
   logic [CHANNELS-1:0] pending_d, pending_q;
   logic [CHANNELS-1:0] overrun_d, overrun_q;
   logic [CHANNELS-1:0] event_c;

   // Synchronizer chain: plain flop-to-flop, nothing between stages
   always_comb begin
      sync_d[0] = bus.i_async_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Synchronizer chain registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
      end
   end

   assign sync_last = sync_q[SYNC_STAGES-1];

   if (FILTER_LEN == 0) begin : g_nofilt
      // Filter bypassed: level is the synchronizer output delayed by one register
      always_comb begin
         level_d = sync_last;
      end
   end else begin : g_filt
      localparam int unsigned CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

      logic [CNT_W-1:0] cnt_d [CHANNELS];
      logic [CNT_W-1:0] cnt_q [CHANNELS];

      // Count consecutive disagreeing cycles; commit the new level when the count would reach FILTER_LEN
      always_comb begin
         level_d = level_q;
         for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = '0;
            if (sync_last[ch] != level_q[ch]) begin
               if (cnt_q[ch] == CNT_W'(FILTER_LEN - 1)) begin
                  level_d[ch] = sync_last[ch];
               end else begin
                  cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
               end
            end
         end
      end

      // Filter counter registers
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
               cnt_q[ch] <= '0;
            end
         end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
               cnt_q[ch] <= cnt_d[ch];
            end
         end
      end
   end

   // Qualify level transitions against the per-channel edge mode (bit0 rising, bit1 falling)
   always_comb begin
      event_c = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         event_c[ch] = (bus.i_mode[2*ch]   &  level_d[ch] & ~level_q[ch]) |
                       (bus.i_mode[2*ch+1] & ~level_d[ch] &  level_q[ch]);
      end
   end

   // Event flags: a new event beats a same-cycle clear; overrun only when an uncleared event is pending
   always_comb begin
      pulse_d   = event_c;
      pending_d = event_c | (pending_q & ~bus.i_clear);
      overrun_d = (event_c & pending_q & ~bus.i_clear) | (overrun_q & ~bus.i_clear);
   end

   // Output registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         level_q   <= '0;
         pulse_q   <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         level_q   <= level_d;
         pulse_q   <= pulse_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.o_level   = level_q;
   assign bus.o_pulse   = pulse_q;
   assign bus.o_pending = pending_q;
   assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_sync_edge_mc.sv
// Testbench for sync_edge_mc: directed stimulus, cycle-by-cycle reference model plus literal checks.
module tb_sync_edge_mc;

   localparam int NCH = 4;
   localparam int S   = 2;
   localparam int FL  = 3;
   localparam int NF  = (FL == 0) ? 1 : FL;
   localparam int HL  = S + NF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   sync_edge_mc_if #(.CHANNELS(NCH)) bus ();

   sync_edge_mc #(
      .CHANNELS   (NCH),
      .SYNC_STAGES(S),
      .FILTER_LEN (FL)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [NCH-1:0] hist [HL];
   logic [NCH-1:0] m_level = '0, m_pulse = '0, m_pend = '0, m_ovr = '0;
   logic [NCH-1:0] lvl_new, ev;
   bit             all_diff;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: level flips once the last NF synchronized samples (input sampled S edges earlier) all disagree
   initial begin
      for (int i = 0; i < HL; i++) hist[i] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < HL; i++) hist[i] = '0;
            m_level = '0; m_pulse = '0; m_pend = '0; m_ovr = '0;
         end else begin
            for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = bus.i_async_in;
            lvl_new = m_level;
            for (int ch = 0; ch < NCH; ch++) begin
               all_diff = 1'b1;
               for (int i = 0; i < NF; i++) begin
                  if (hist[S+i][ch] == m_level[ch]) all_diff = 1'b0;
               end
               if (all_diff) lvl_new[ch] = hist[S][ch];
            end
            for (int ch = 0; ch < NCH; ch++) begin
               ev[ch] = (lvl_new[ch] && !m_level[ch] && bus.i_mode[2*ch]) ||
                        (!lvl_new[ch] && m_level[ch] && bus.i_mode[2*ch+1]);
               if (ev[ch]) begin
                  if (m_pend[ch] && !bus.i_clear[ch]) m_ovr[ch] = 1'b1;
                  else if (bus.i_clear[ch])           m_ovr[ch] = 1'b0;
                  m_pend[ch] = 1'b1;
               end else if (bus.i_clear[ch]) begin
                  m_pend[ch] = 1'b0;
                  m_ovr[ch]  = 1'b0;
               end
            end
            m_level = lvl_new;
            m_pulse = ev;
         end
      end
   end

   // Compare DUT against model every cycle, mid-period
   initial begin
      forever begin
         @(negedge clk);
         chk("model_level",   32'(bus.o_level),   32'(m_level));
         chk("model_pulse",   32'(bus.o_pulse),   32'(m_pulse));
         chk("model_pending", 32'(bus.o_pending), 32'(m_pend));
         chk("model_overrun", 32'(bus.o_overrun), 32'(m_ovr));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic tick_count(input int n, input int ch, inout int cnt);
      repeat (n) begin
         tick(1);
         if (bus.o_pulse[ch]) cnt++;
      end
   endtask

   int pc;

   initial begin
      bus.i_async_in = '0;
      bus.i_mode     = 8'b11_11_01_01;
      bus.i_clear    = '0;
      #1 rst_n = 1'b0;
      tick(3);
      chk("reset_level", 32'(bus.o_level), 32'h0);
      chk("reset_flags", 32'({bus.o_pulse, bus.o_pending, bus.o_overrun}), 32'h0);
      rst_n = 1'b1;
      tick(4);

      // ch0 rising, mode 01: level and pulse at edge k+5
      bus.i_async_in[0] = 1'b1;
      tick(4);
      chk("ch0_lvl_k4", 32'(bus.o_level[0]), 32'd0);
      tick(1);
      chk("ch0_lvl_k5",   32'(bus.o_level[0]),   32'd1);
      chk("ch0_pulse_k5", 32'(bus.o_pulse[0]),   32'd1);
      chk("ch0_pend_k5",  32'(bus.o_pending[0]), 32'd1);
      tick(1);
      chk("ch0_pulse_k6", 32'(bus.o_pulse[0]),   32'd0);
      chk("ch0_pend_k6",  32'(bus.o_pending[0]), 32'd1);

      // ch1 glitch of two samples: filtered out
      bus.i_async_in[1] = 1'b1;
      tick(2);
      bus.i_async_in[1] = 1'b0;
      pc = 0;
      tick_count(10, 1, pc);
      chk("ch1_glitch_pulses", 32'(pc), 32'd0);
      chk("ch1_glitch_lvl",    32'(bus.o_level[1]),   32'd0);
      chk("ch1_glitch_pend",   32'(bus.o_pending[1]), 32'd0);

      // ch2 mode 11: rise then fall -> two pulses, pending and overrun
      pc = 0;
      bus.i_async_in[2] = 1'b1;
      tick_count(10, 2, pc);
      bus.i_async_in[2] = 1'b0;
      tick_count(10, 2, pc);
      chk("ch2_pulses",  32'(pc), 32'd2);
      chk("ch2_pend",    32'(bus.o_pending[2]), 32'd1);
      chk("ch2_ovr",     32'(bus.o_overrun[2]), 32'd1);
      bus.i_clear[2] = 1'b1;
      tick(1);
      bus.i_clear[2] = 1'b0;
      chk("ch2_clr_pend", 32'(bus.o_pending[2]), 32'd0);
      chk("ch2_clr_ovr",  32'(bus.o_overrun[2]), 32'd0);

      // ch3: clear coincident with an event while overrun is set -> pending 1, overrun 0
      bus.i_async_in[3] = 1'b1;
      tick(10);
      bus.i_async_in[3] = 1'b0;
      tick(10);
      chk("ch3_ovr_pre", 32'(bus.o_overrun[3]), 32'd1);
      bus.i_async_in[3] = 1'b1;
      tick(4);
      bus.i_clear[3] = 1'b1;
      tick(1);
      bus.i_clear[3] = 1'b0;
      chk("ch3_coinc_pulse", 32'(bus.o_pulse[3]),   32'd1);
      chk("ch3_coinc_pend",  32'(bus.o_pending[3]), 32'd1);
      chk("ch3_coinc_ovr",   32'(bus.o_overrun[3]), 32'd0);

      // ch0: clear leaves level alone; mode 00 tracks level silently; mode 10 then one falling pulse
      bus.i_clear[0] = 1'b1;
      tick(1);
      bus.i_clear[0] = 1'b0;
      chk("ch0_clr_pend", 32'(bus.o_pending[0]), 32'd0);
      chk("ch0_clr_lvl",  32'(bus.o_level[0]),   32'd1);
      bus.i_mode[1:0] = 2'b00;
      pc = 0;
      bus.i_async_in[0] = 1'b0;
      tick_count(8, 0, pc);
      chk("ch0_m00_lvl0", 32'(bus.o_level[0]), 32'd0);
      bus.i_async_in[0] = 1'b1;
      tick_count(8, 0, pc);
      chk("ch0_m00_lvl1",   32'(bus.o_level[0]),   32'd1);
      chk("ch0_m00_pulses", 32'(pc), 32'd0);
      chk("ch0_m00_pend",   32'(bus.o_pending[0]), 32'd0);
      bus.i_mode[1:0] = 2'b10;
      pc = 0;
      bus.i_async_in[0] = 1'b0;
      tick_count(8, 0, pc);
      chk("ch0_m10_pulses", 32'(pc), 32'd1);
      chk("ch0_m10_pend",   32'(bus.o_pending[0]), 32'd1);

      // ch1: reset mid-filter, input held high across release -> rising event after full latency
      bus.i_async_in[1] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_level", 32'(bus.o_level), 32'h0);
      chk("rst_mid_flags", 32'({bus.o_pulse, bus.o_pending, bus.o_overrun}), 32'h0);
      tick(3);
      rst_n = 1'b1;
      tick(4);
      chk("ch1_rel_lvl_k4", 32'(bus.o_level[1]), 32'd0);
      tick(1);
      chk("ch1_rel_lvl_k5",   32'(bus.o_level[1]),   32'd1);
      chk("ch1_rel_pulse_k5", 32'(bus.o_pulse[1]),   32'd1);
      chk("ch1_rel_pend_k5",  32'(bus.o_pending[1]), 32'd1);
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
